// File: rtl/map_ram_arbiter_if.sv
// map_ram_arbiter_if: display, game and RAM-side signals of the map RAM arbiter.
//   Display: disp_req/disp_addr in; disp_gnt, disp_rdata, disp_valid out.
//   Game:    game_req/game_we/game_addr/game_wdata in;
//            game_gnt, game_rdata, game_valid, game_err out.
//   RAM:     ram_we, ram_addr, ram_din out; ram_dout in (synchronous RAM, 1-cycle read).
//   modport slave is the arbiter; modport master is the requesters/RAM side.
interface map_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_valid;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_gnt;
    logic [DATA_W-1:0] game_rdata;
    logic              game_valid;
    logic              game_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, ram_dout,
        output disp_gnt, disp_rdata, disp_valid, game_gnt, game_rdata, game_valid, game_err,
               ram_we, ram_addr, ram_din
    );

    modport master (
        output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, ram_dout,
        input  disp_gnt, disp_rdata, disp_valid, game_gnt, game_rdata, game_valid, game_err,
               ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port map RAM between the display (read-only) and game logic.
//   Ports: clk, rst (async, active-high), bus (map_ram_arbiter_if.slave).
//   Grants are combinational; RAM-side outputs are registered; read data returns 2 cycles after gnt.
//   Default: display priority with a MAX_WAIT starvation guard for the game.
//   `define ARB_ROUND_ROBIN_EN: the winner alternates on contention (display first after reset).
module map_ram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int MAP_CELLS = 300,
    parameter int MAX_WAIT  = 4
) (
    input logic              clk,
    input logic              rst,
    map_ram_arbiter_if.slave bus
);
    localparam int CELL_W = ADDR_W - 1;

    typedef enum logic [1:0] {NONE, DISP, GAME_RD, GAME_WR} tag_e;

    tag_e              issue_q, issue_d, ret_q, ret_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d, game_hold_q, game_hold_d;
    logic              we_q, we_d, err_q, err_d, ret_oor_q, ret_oor_d;
    logic              game_wins, disp_gnt, game_gnt, oor, disp_valid, game_valid;
    logic [DATA_W-1:0] disp_rdata, game_rdata;

    assign oor = bus.game_addr[CELL_W-1:0] >= CELL_W'(MAP_CELLS);

`ifdef ARB_ROUND_ROBIN_EN
    // prio_game_q: the game wins the next contention (set after a display grant)
    logic prio_game_q, prio_game_d;
    always_comb begin
        game_wins   = bus.game_req && (!bus.disp_req || prio_game_q);
        prio_game_d = game_gnt ? 1'b0 : disp_gnt ? 1'b1 : prio_game_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) prio_game_q <= 1'b0;
        else     prio_game_q <= prio_game_d;
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    always_comb begin
        game_wins = bus.game_req && (!bus.disp_req || wait_q == WAIT_W'(MAX_WAIT));
        wait_d    = (bus.game_req && !game_gnt)
                  ? ((wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + 1'b1) : '0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
`endif

    always_comb begin
        game_gnt = game_wins;
        disp_gnt = bus.disp_req && !game_wins;
        // An out-of-range write is granted but never reaches the RAM, so it carries no tag.
        issue_d  = game_gnt ? (bus.game_we ? (oor ? NONE : GAME_WR) : GAME_RD)
                 : disp_gnt ? DISP : NONE;
        addr_d   = game_gnt ? bus.game_addr : disp_gnt ? bus.disp_addr : addr_q;
        din_d    = (game_gnt && bus.game_we) ? bus.game_wdata : din_q;
        we_d     = issue_d == GAME_WR;
        err_d    = game_gnt && oor;
        ret_d    = issue_q;
        ret_oor_d = err_q;
    end

    always_comb begin
        disp_valid  = ret_q == DISP;
        game_valid  = ret_q == GAME_RD;
        disp_rdata  = disp_valid ? bus.ram_dout : disp_hold_q;
        game_rdata  = game_valid ? (ret_oor_q ? '0 : bus.ram_dout) : game_hold_q;
        disp_hold_d = disp_rdata;
        game_hold_d = game_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q     <= NONE;
            ret_q       <= NONE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ret_oor_q   <= 1'b0;
            disp_hold_q <= '0;
            game_hold_q <= '0;
        end else begin
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ret_oor_q   <= ret_oor_d;
            disp_hold_q <= disp_hold_d;
            game_hold_q <= game_hold_d;
        end
    end

    assign bus.disp_gnt   = disp_gnt;
    assign bus.game_gnt   = game_gnt;
    assign bus.disp_valid = disp_valid;
    assign bus.game_valid = game_valid;
    assign bus.disp_rdata = disp_rdata;
    assign bus.game_rdata = game_rdata;
    assign bus.game_err   = err_q;
    assign bus.ram_we     = we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb_map_ram_arbiter: table-driven bench for map_ram_arbiter with a synchronous RAM model.
module tb_map_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    map_ram_arbiter_if bus ();
    map_ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // {disp_gnt, game_gnt, ram_we, ram_addr, ram_din, game_err, disp_valid, disp_rdata, game_valid, game_rdata}
    logic [39:0] act;
    assign act = {bus.disp_gnt, bus.game_gnt, bus.ram_we, bus.ram_addr, bus.ram_din, bus.game_err,
                  bus.disp_valid, bus.disp_rdata, bus.game_valid, bus.game_rdata};

    typedef struct {
        logic        dr;
        logic [9:0]  da;
        logic        gr;
        logic        gw;
        logic [9:0]  ga;
        logic [7:0]  gd;
        logic [39:0] e;
    } vec_t;

    vec_t v [21];
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [39:0] o(input int dg, gg, we, ra, din, err, dv, drd, gv, grd);
        return {1'(dg), 1'(gg), 1'(we), 10'(ra), 8'(din), 1'(err), 1'(dv), 8'(drd), 1'(gv), 8'(grd)};
    endfunction

    function automatic vec_t r(input int dr, da, gr, gw, ga, gd, input logic [39:0] e);
        vec_t x;
        x.dr = 1'(dr); x.da = 10'(da); x.gr = 1'(gr); x.gw = 1'(gw);
        x.ga = 10'(ga); x.gd = 8'(gd); x.e = e;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        bus.disp_req = x.dr; bus.disp_addr = x.da;
        bus.game_req = x.gr; bus.game_we = x.gw; bus.game_addr = x.ga; bus.game_wdata = x.gd;
    endtask

    task automatic chk(input string nm, input logic [39:0] a, input logic [39:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    logic [9:0] exp_g = 10'b10_1010_1010;
`else
    logic [9:0] exp_g = 10'b10_0001_0000;
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h005] = 8'hC3; mem[10'h001] = 8'h11; mem[10'h002] = 8'h22;
        mem[10'h003] = 8'h33; mem[10'h12C] = 8'hEE;
        //       dr  da     gr gw ga     gd        dg gg we ra     din   er dv drd   gv grd
        v[0]  = r(1, 'h005, 0, 0, 0,     0,    o(1, 0, 0, 0,     0,    0, 0, 0,    0, 0));
        v[1]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h005, 0,    0, 0, 0,    0, 0));
        v[2]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h005, 0,    0, 1, 'hC3, 0, 0));
        v[3]  = r(0, 0,     1, 1, 'h22C, 'hFF, o(0, 1, 0, 'h005, 0,    0, 0, 'hC3, 0, 0));
        v[4]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 1, 'h22C, 'hFF, 0, 0, 'hC3, 0, 0));
        v[5]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h22C, 'hFF, 0, 0, 'hC3, 0, 0));
        v[6]  = r(0, 0,     1, 0, 'h22C, 0,    o(0, 1, 0, 'h22C, 'hFF, 0, 0, 'hC3, 0, 0));
        v[7]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h22C, 'hFF, 0, 0, 'hC3, 0, 0));
        v[8]  = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h22C, 'hFF, 0, 0, 'hC3, 1, 'hFF));
        v[9]  = r(0, 0,     1, 0, 'h12C, 0,    o(0, 1, 0, 'h22C, 'hFF, 0, 0, 'hC3, 0, 'hFF));
        v[10] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h12C, 'hFF, 1, 0, 'hC3, 0, 'hFF));
        v[11] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h12C, 'hFF, 0, 0, 'hC3, 1, 0));
        v[12] = r(1, 'h001, 0, 0, 0,     0,    o(1, 0, 0, 'h12C, 'hFF, 0, 0, 'hC3, 0, 0));
        v[13] = r(0, 0,     1, 0, 'h002, 0,    o(0, 1, 0, 'h001, 'hFF, 0, 0, 'hC3, 0, 0));
        v[14] = r(1, 'h003, 0, 0, 0,     0,    o(1, 0, 0, 'h002, 'hFF, 0, 1, 'h11, 0, 0));
        v[15] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h003, 'hFF, 0, 0, 'h11, 1, 'h22));
        v[16] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h003, 'hFF, 0, 1, 'h33, 0, 'h22));
        v[17] = r(0, 0,     1, 1, 'h12C, 'hAA, o(0, 1, 0, 'h003, 'hFF, 0, 0, 'h33, 0, 'h22));
        v[18] = r(1, 'h005, 0, 0, 0,     0,    o(1, 0, 0, 'h12C, 'hAA, 1, 0, 'h33, 0, 'h22));
        v[19] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h005, 'hAA, 0, 0, 'h33, 0, 'h22));
        v[20] = r(0, 0,     0, 0, 0,     0,    o(0, 0, 0, 'h005, 'hAA, 0, 1, 'hC3, 0, 'h22));

        drive(r(0, 0, 0, 0, 0, 0, '0));
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", act, '0);
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive(v[i]);
            @(negedge clk);
            chk($sformatf("row%0d", i), act, v[i].e);
            @(posedge clk); #1;
        end
        chk("oor_write_blocked", {32'd0, mem[10'h12C]}, {32'd0, 8'hEE});

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drive(r(1, 'h010, 1, 0, 'h011, 0, '0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("contend%0d", i), {38'd0, bus.disp_gnt, bus.game_gnt},
                {38'd0, !exp_g[i], exp_g[i]});
            @(posedge clk); #1;
        end
        drive(r(0, 0, 0, 0, 0, 0, '0));
        repeat (3) @(posedge clk);
        #1;

        drive(r(0, 0, 1, 0, 'h002, 0, '0));
        @(negedge clk);
        chk("rst_mid_gnt", {39'd0, bus.game_gnt}, {39'd0, 1'b1});
        @(posedge clk); #1;
        drive(r(0, 0, 0, 0, 0, 0, '0));
        rst = 1'b1;
        #1 chk("rst_mid_outputs", act, '0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_valid%0d", i), {39'd0, bus.game_valid}, '0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
